// File: rtl/stream_mux_pkg.sv
// Shared definitions for stream_mux: grant-mode encodings and the packed-bus slice helper.
// The slice macro lives beside the package so every file that imports the package can use it.
`ifndef STREAM_MUX_SLICE_DEFINED
`define STREAM_MUX_SLICE_DEFINED
`define SM_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

package stream_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/stream_mux_if.sv
// Handshake bundle for stream_mux: N packed input channels, one registered output channel.
interface stream_mux_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
);
    import stream_mux_pkg::*;

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SEL_W-1:0]   sel;
    logic               mode;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_src;
    logic               out_valid;
    logic               out_ready;
    logic               sel_err;

    modport slave (
        input  in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_src, out_valid, sel_err
    );

    modport master (
        output in_data, in_valid, sel, mode, out_ready,
        input  in_ready, out_data, out_src, out_valid, sel_err
    );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requesting channel at or after ptr, wrapping modulo N.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_grant,
    output logic             o_grant_vld
);

    always_comb begin
        int idx;
        idx         = 0;
        o_grant     = '0;
        o_grant_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            // Explicit wrap keeps the search correct when N is not a power of two.
            idx = int'(i_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!o_grant_vld && i_req[idx]) begin
                o_grant     = SEL_W'(idx);
                o_grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N-to-1 registered stream multiplexer with select-directed or round-robin grant.
// Output register plus one skid register form a 2-entry FIFO so in_ready never depends on out_ready.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input logic         clk,
    input logic         rst,
    stream_mux_if.slave bus
);

    localparam int SEL_W = $clog2(N);

    logic [SEL_W-1:0] w_rr_grant;
    logic             w_rr_vld;
    logic [SEL_W-1:0] w_grant;
    logic             w_grant_vld;
    logic             w_sel_ok;
    logic             w_space;
    logic [N-1:0]     w_ready;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_in_slice;

    logic [SEL_W-1:0] r_rr_ptr;
    logic             r_sel_err;
    logic [WIDTH-1:0] r_skid_data_p0;
    logic [SEL_W-1:0] r_skid_src_p0;
    logic             r_skid_vld_p0;
    logic [WIDTH-1:0] r_out_data_p1;
    logic [SEL_W-1:0] r_out_src_p1;
    logic             r_vld_p1;

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .i_req       (bus.in_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_rr_grant),
        .o_grant_vld (w_rr_vld)
    );

    assign w_sel_ok = 32'(bus.sel) < N;

    always_comb begin
        w_grant     = bus.sel;
        w_grant_vld = w_sel_ok;
        if (bus.mode == MODE_RR) begin
            w_grant     = w_rr_grant;
            w_grant_vld = w_rr_vld;
        end
    end

    // Room for a new beat whenever the skid register is empty (count < 2).
    assign w_space = !r_skid_vld_p0;

    always_comb begin
        w_ready = '0;
        if (!rst && w_space && w_grant_vld) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    assign w_push     = |(w_ready & bus.in_valid);
    assign w_pop      = r_vld_p1 && bus.out_ready;
    assign w_in_slice = `SM_SLICE(bus.in_data, w_grant, WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_sel_err <= 1'b0;
        end else begin
            if (w_push && bus.mode == MODE_RR) begin
                r_rr_ptr <= (32'(w_grant) == N - 1) ? '0 : w_grant + 1'b1;
            end
            if (bus.mode == MODE_SEL && !w_sel_ok) begin
                r_sel_err <= 1'b1;
            end
        end
    end

    // p0 = skid stage, p1 = output stage; the output register always holds the oldest entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_data_p0 <= '0;
            r_skid_src_p0  <= '0;
            r_skid_vld_p0  <= 1'b0;
            r_out_data_p1  <= '0;
            r_out_src_p1   <= '0;
            r_vld_p1       <= 1'b0;
        end else if (w_pop) begin
            if (r_skid_vld_p0) begin
                r_out_data_p1 <= r_skid_data_p0;
                r_out_src_p1  <= r_skid_src_p0;
                r_skid_vld_p0 <= 1'b0;
            end else if (w_push) begin
                r_out_data_p1 <= w_in_slice;
                r_out_src_p1  <= w_grant;
            end else begin
                r_vld_p1 <= 1'b0;
            end
        end else if (w_push) begin
            if (r_vld_p1) begin
                r_skid_data_p0 <= w_in_slice;
                r_skid_src_p0  <= w_grant;
                r_skid_vld_p0  <= 1'b1;
            end else begin
                r_out_data_p1 <= w_in_slice;
                r_out_src_p1  <= w_grant;
                r_vld_p1      <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_data  = r_out_data_p1;
    assign bus.out_src   = r_out_src_p1;
    assign bus.out_valid = r_vld_p1;
    assign bus.sel_err   = r_sel_err;

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: an N=4 instance for the main scenarios, an N=3 instance for sel_err and wrap.
module tb_stream_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    stream_mux_if #(.WIDTH(32), .N(4), .SEL_W(2)) ifa ();
    stream_mux_if #(.WIDTH(32), .N(3), .SEL_W(2)) ifb ();

    stream_mux #(.WIDTH(32), .N(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    stream_mux #(.WIDTH(32), .N(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
        ifa.in_data = {d3, d2, d1, d0};
    endtask

    task automatic test_reset();
        ifa.mode = 1'b0; ifa.sel = 2'd0; ifa.in_valid = 4'hF; ifa.out_ready = 1'b1;
        set_a(32'h11, 32'h22, 32'h33, 32'h44);
        ifb.mode = 1'b0; ifb.sel = 2'd0; ifb.in_valid = 3'b000; ifb.out_ready = 1'b1;
        ifb.in_data = '0;
        #2;
        if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0h want 0", ifa.out_valid); end n_cmp++;
        if (ifa.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %0h want 0", ifa.out_data); end n_cmp++;
        if (ifa.out_src !== 2'd0) begin n_fail++; $display("FAIL reset_out_src: got %0h want 0", ifa.out_src); end n_cmp++;
        if (ifa.sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err: got %0h want 0", ifa.sel_err); end n_cmp++;
        if (ifa.in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %0h want 0", ifa.in_ready); end n_cmp++;
        tick();
        if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_held_valid: got %0h want 0", ifa.out_valid); end n_cmp++;
        rst = 1'b0;
        ifa.in_valid = 4'h0;
        tick();
    endtask

    task automatic test_sel_mode();
        logic [31:0] exp_d;
        ifa.mode = 1'b0; ifa.sel = 2'd2; ifa.in_valid = 4'hF; ifa.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_a(32'h100 * (c + 1), 32'h100 * (c + 1) + 1, 32'h100 * (c + 1) + 2, 32'h100 * (c + 1) + 3);
            exp_d = 32'h100 * (c + 1) + 2;
            #1;
            if (ifa.in_ready !== 4'b0100) begin n_fail++; $display("FAIL sel_in_ready[%0d]: got %0h want 4", c, ifa.in_ready); end n_cmp++;
            tick();
            if (ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL sel_out_valid[%0d]: got %0h want 1", c, ifa.out_valid); end n_cmp++;
            if (ifa.out_data !== exp_d) begin n_fail++; $display("FAIL sel_out_data[%0d]: got %0h want %0h", c, ifa.out_data, exp_d); end n_cmp++;
            if (ifa.out_src !== 2'd2) begin n_fail++; $display("FAIL sel_out_src[%0d]: got %0h want 2", c, ifa.out_src); end n_cmp++;
        end
        ifa.in_valid = 4'h0;
        tick();
        if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL sel_drain: got %0h want 0", ifa.out_valid); end n_cmp++;
    endtask

    task automatic test_round_robin();
        logic [1:0] seq_all [5];
        logic [1:0] seq_odd [4];
        logic [3:0] one;
        logic [3:0] exp_rdy;
        seq_all = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        seq_odd = '{2'd1, 2'd3, 2'd1, 2'd3};
        one = 4'b0001;
        ifa.mode = 1'b1; ifa.sel = 2'd0; ifa.in_valid = 4'hF; ifa.out_ready = 1'b1;
        set_a(32'hC0, 32'hC1, 32'hC2, 32'hC3);
        for (int k = 0; k < 5; k++) begin
            exp_rdy = one << seq_all[k];
            #1;
            if (ifa.in_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_all_ready[%0d]: got %0h want %0h", k, ifa.in_ready, exp_rdy); end n_cmp++;
            tick();
            if (ifa.out_src !== seq_all[k]) begin n_fail++; $display("FAIL rr_all_src[%0d]: got %0d want %0d", k, ifa.out_src, seq_all[k]); end n_cmp++;
            if (ifa.out_data !== 32'hC0 + 32'(seq_all[k])) begin n_fail++; $display("FAIL rr_all_data[%0d]: got %0h want %0h", k, ifa.out_data, 32'hC0 + 32'(seq_all[k])); end n_cmp++;
        end
        ifa.in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (ifa.out_src !== seq_odd[k]) begin n_fail++; $display("FAIL rr_odd_src[%0d]: got %0d want %0d", k, ifa.out_src, seq_odd[k]); end n_cmp++;
        end
        ifa.in_valid = 4'h0;
        tick();
        if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got %0h want 0", ifa.out_valid); end n_cmp++;
    endtask

    task automatic test_backpressure();
        ifa.mode = 1'b0; ifa.sel = 2'd0; ifa.out_ready = 1'b0; ifa.in_valid = 4'b0001;
        set_a(32'hA, 32'h0, 32'h0, 32'h0);
        #1;
        if (ifa.in_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_ready_a: got %0h want 1", ifa.in_ready); end n_cmp++;
        tick();
        if (ifa.out_data !== 32'hA) begin n_fail++; $display("FAIL bp_first: got %0h want a", ifa.out_data); end n_cmp++;
        set_a(32'hB, 32'h0, 32'h0, 32'h0);
        #1;
        if (ifa.in_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_ready_skid: got %0h want 1", ifa.in_ready); end n_cmp++;
        tick();
        set_a(32'hC, 32'h0, 32'h0, 32'h0);
        #1;
        if (ifa.in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_full_ready: got %0h want 0", ifa.in_ready); end n_cmp++;
        if (ifa.out_data !== 32'hA) begin n_fail++; $display("FAIL bp_hold_1: got %0h want a", ifa.out_data); end n_cmp++;
        tick();
        if (ifa.out_data !== 32'hA || ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_2: got %0h/%0h want a/1", ifa.out_data, ifa.out_valid); end n_cmp++;
        if (ifa.in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_still_full: got %0h want 0", ifa.in_ready); end n_cmp++;
        ifa.out_ready = 1'b1;
        tick();
        if (ifa.out_data !== 32'hB || ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_b: got %0h/%0h want b/1", ifa.out_data, ifa.out_valid); end n_cmp++;
        tick();
        ifa.in_valid = 4'h0;
        if (ifa.out_data !== 32'hC || ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_c: got %0h/%0h want c/1", ifa.out_data, ifa.out_valid); end n_cmp++;
        tick();
        if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %0h want 0", ifa.out_valid); end n_cmp++;
    endtask

    task automatic test_reset_traffic();
        ifa.mode = 1'b0; ifa.sel = 2'd0; ifa.out_ready = 1'b0; ifa.in_valid = 4'b0001;
        set_a(32'hD1, 32'h0, 32'h0, 32'h0);
        tick();
        set_a(32'hD2, 32'h0, 32'h0, 32'h0);
        tick();
        if (ifa.in_ready !== 4'b0000) begin n_fail++; $display("FAIL rt_full: got %0h want 0", ifa.in_ready); end n_cmp++;
        #3;
        rst = 1'b1;
        #1;
        if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL rt_valid_drop: got %0h want 0", ifa.out_valid); end n_cmp++;
        if (ifa.in_ready !== 4'b0000) begin n_fail++; $display("FAIL rt_ready_low: got %0h want 0", ifa.in_ready); end n_cmp++;
        if (ifa.out_data !== 32'h0) begin n_fail++; $display("FAIL rt_data_clr: got %0h want 0", ifa.out_data); end n_cmp++;
        #2;
        rst = 1'b0;
        ifa.out_ready = 1'b1;
        set_a(32'hE1, 32'h0, 32'h0, 32'h0);
        #1;
        if (ifa.in_ready !== 4'b0001) begin n_fail++; $display("FAIL rt_ready_back: got %0h want 1", ifa.in_ready); end n_cmp++;
        tick();
        if (ifa.out_valid !== 1'b1 || ifa.out_data !== 32'hE1) begin n_fail++; $display("FAIL rt_first: got %0h/%0h want 1/e1", ifa.out_valid, ifa.out_data); end n_cmp++;
        ifa.in_valid = 4'h0;
        tick();
        if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL rt_no_stale: got %0h want 0", ifa.out_valid); end n_cmp++;
    endtask

    task automatic test_sel_err_n3();
        logic [1:0] seq [4];
        seq = '{2'd0, 2'd1, 2'd2, 2'd0};
        ifb.mode = 1'b0; ifb.sel = 2'd3; ifb.in_valid = 3'b111; ifb.out_ready = 1'b1;
        ifb.in_data = {32'h302, 32'h301, 32'h300};
        #1;
        if (ifb.in_ready !== 3'b000) begin n_fail++; $display("FAIL n3_bad_ready: got %0h want 0", ifb.in_ready); end n_cmp++;
        if (ifb.sel_err !== 1'b0) begin n_fail++; $display("FAIL n3_err_pre: got %0h want 0", ifb.sel_err); end n_cmp++;
        tick();
        if (ifb.sel_err !== 1'b1) begin n_fail++; $display("FAIL n3_err_set: got %0h want 1", ifb.sel_err); end n_cmp++;
        if (ifb.out_valid !== 1'b0) begin n_fail++; $display("FAIL n3_no_out: got %0h want 0", ifb.out_valid); end n_cmp++;
        ifb.sel = 2'd0;
        #1;
        if (ifb.in_ready !== 3'b001) begin n_fail++; $display("FAIL n3_sel0_ready: got %0h want 1", ifb.in_ready); end n_cmp++;
        tick();
        if (ifb.sel_err !== 1'b1) begin n_fail++; $display("FAIL n3_err_sticky: got %0h want 1", ifb.sel_err); end n_cmp++;
        if (ifb.out_data !== 32'h300 || ifb.out_src !== 2'd0) begin n_fail++; $display("FAIL n3_sel0_out: got %0h/%0d want 300/0", ifb.out_data, ifb.out_src); end n_cmp++;
        ifb.mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (ifb.out_src !== seq[k]) begin n_fail++; $display("FAIL n3_rr_wrap[%0d]: got %0d want %0d", k, ifb.out_src, seq[k]); end n_cmp++;
        end
        ifb.in_valid = 3'b000;
        tick();
        if (ifb.sel_err !== 1'b1) begin n_fail++; $display("FAIL n3_err_end: got %0h want 1", ifb.sel_err); end n_cmp++;
        if (ifa.sel_err !== 1'b0) begin n_fail++; $display("FAIL n4_no_err: got %0h want 0", ifa.sel_err); end n_cmp++;
    endtask

    initial begin
        test_reset();
        test_sel_mode();
        test_round_robin();
        test_backpressure();
        test_reset_traffic();
        test_sel_err_n3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised N-to-1 registered stream multiplexer for the RISC-V datapath; it generalises the 2:1 combinational select into a pipelined select stage. It has configurable width and channel count, a valid/ready handshake on every channel and two grant modes: select-directed and round-robin. Typical uses are merging requests into a shared unit, such as load/store and fetch traffic into the memory port, and staging operand-source selection across a pipeline boundary.

## Interface
Parameters:
- WIDTH, 32, data width per channel
- N, 4, number of input channels (2..16, need not be a power of two)
- SEL_W, $clog2(N), localparam width of select and source-index fields

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready; at most one bit set per cycle
- sel  input  SEL_W  channel to pass when mode=0
- mode  input  1  0 = select-directed, 1 = round-robin
- out_data  output  WIDTH  registered output data
- out_src  output  SEL_W  index of the channel that produced out_data
- out_valid  output  1  output valid
- out_ready  input  1  downstream ready
- sel_err  output  1  sticky flag: sel >= N was seen while mode=0

## Operation
- Grant, combinational:
  - mode=0: grant = sel if sel < N, otherwise no grant.
  - mode=1: grant = first i with in_valid[i], searching rr_ptr, rr_ptr+1, … modulo N.
- in_ready[grant] = space; all other in_ready bits are 0. space = (count < 2). in_ready never depends on out_ready.
- Accept: in_valid[grant] && in_ready[grant]. On accept, {in_data slice, grant} is pushed into a 2-entry FIFO made of an output register plus a skid register.
- Pop: out_valid && out_ready.
- count:
  - push without pop: +1
  - pop without push: −1
  - push and pop together: unchanged
- The output register always holds the oldest entry.
- rr_ptr updates only on an accept in mode=1: rr_ptr ← (grant+1) mod N, with explicit wrap for non-power-of-two N. It is held in mode=0 and across mode changes.
- mode and sel are sampled every cycle with no locking. A change takes effect on the next grant evaluation and never disturbs buffered entries.
- sel_err is set when mode=0 and sel >= N. It is cleared only by rst.
- Data is never reordered, dropped or duplicated.

## Timing
- Reset (asynchronous, immediate) forces:
  - out_valid=0, out_data=0, out_src=0, sel_err=0
  - count=0, rr_ptr=0
  - in_ready=0 while rst is high
- A reset asserted mid-transfer discards both buffered entries.
- Latency: accept at edge k gives out_valid=1 after edge k, with data presented in cycle k+1.
- Throughput: one transfer per cycle sustained while out_ready=1. Steady state is count=1, with push and pop each cycle.
- Backpressure:
  - out_ready=0 with count=1 still accepts one more beat, which goes to the skid register; count becomes 2.
  - At count=2 all in_ready bits are 0.
  - When out_ready rises at count=2, the first pop moves the skid entry into the output register in the same edge.
- out_data and out_src stay stable while out_valid && !out_ready.

## Structure
- A shared package/header holds the mode encodings MODE_SEL=1'b0 and MODE_RR=1'b1, plus the slice helper macro for the packed in_data bus.
- Sub-module rr_arbiter (parameters N, SEL_W): inputs req[N-1:0], ptr; outputs grant index and grant_vld. It is purely combinational.
- The rr_ptr register, the FIFO and sel_err live in stream_mux.

## Test plan
- Reset during traffic: N=4, count=2, assert rst mid-cycle → out_valid drops immediately, in_ready=0; after release the first accept appears one cycle later.
- mode=0, sel=2, in_valid=4'b1111, out_ready=1 → only in_ready[2]=1; out_data=ch2 data, out_src=2, one beat per cycle.
- mode=1, all four channels valid continuously → out_src sequence 0,1,2,3,0,…; with only ch1 and ch3 valid → 1,3,1,3.
- Backpressure: stream 0xA,0xB,0xC with out_ready low after the first accept → count reaches 2, in_ready=0, 0xC held upstream; raising out_ready outputs 0xA,0xB,0xC in order with no bubble after the first.
- N=3, mode=0, sel=3 → no in_ready, no output, sel_err=1 and stays set after sel returns to 0.
